// File: rtl/inv_duty_ctrl.sv
// Inverter duty-word controller: setpoint arbitration, tick-paced duty ramp, and fault handling.
// Optional build macro INV_SOFTSTART_EN limits each tick's duty change to STEP.
module inv_duty_ctrl #(
    parameter int unsigned DW   = 10,
    parameter int unsigned DMAX = 1000,
    parameter int unsigned STEP = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    input  logic          upd_tick,
    input  logic          req_a,
    input  logic          req_b,
    input  logic [DW-1:0] set_a,
    input  logic [DW-1:0] set_b,
    output logic          gnt_a,
    output logic          gnt_b,
    input  logic          fault,
    output logic [DW-1:0] d_inv,
    output logic [1:0]    state,
    output logic          ramp_busy
);

`ifdef INV_SOFTSTART_EN
    localparam bit SoftStart = 1'b1;
`else
    localparam bit SoftStart = 1'b0;
`endif

    localparam logic [DW-1:0] DmaxW = DW'(DMAX);
    // Without soft start the per-tick limit never bites, so RAMP finishes on its first tick.
    localparam logic [DW-1:0] StepLim = SoftStart ? DW'(STEP) : DmaxW;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StRamp  = 2'b01,
        StHold  = 2'b10,
        StFault = 2'b11
    } state_e;

    state_e        state_q;
    state_e        st_norm;
    logic [DW-1:0] d_inv_q;
    logic [DW-1:0] target_q;
    logic          rr_q;
    logic          gnt_a_q;
    logic          gnt_b_q;
    logic          ramp_busy_q;

    logic [DW-1:0] set_a_cl;
    logic [DW-1:0] set_b_cl;
    logic          win_a;
    logic          win_b;
    logic [DW-1:0] gap;
    logic [DW-1:0] d_step;
    logic [DW-1:0] d_next;

    always_comb begin
        set_a_cl = (set_a > DmaxW) ? DmaxW : set_a;
        set_b_cl = (set_b > DmaxW) ? DmaxW : set_b;
        // rr_q low favours A when both requesters are pending.
        win_a    = req_a && (!req_b || !rr_q);
        win_b    = req_b && !win_a;
    end

    always_comb begin
        gap    = '0;
        d_step = d_inv_q;
        if (target_q > d_inv_q) begin
            gap    = target_q - d_inv_q;
            if (gap > StepLim) gap = StepLim;
            d_step = d_inv_q + gap;
        end else if (target_q < d_inv_q) begin
            gap    = d_inv_q - target_q;
            if (gap > StepLim) gap = StepLim;
            d_step = d_inv_q - gap;
        end
        if (d_step > DmaxW) d_step = DmaxW;
        d_next = (state_q == StRamp && upd_tick) ? d_step : d_inv_q;
    end

    // Next state for the non-fault path; the ramp compare uses the target held before any grant.
    always_comb begin
        st_norm = state_q;
        if (state_q == StRamp) begin
            if (d_next == target_q) st_norm = (target_q == '0) ? StIdle : StHold;
        end else if (target_q != d_inv_q) begin
            st_norm = StRamp;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            d_inv_q     <= '0;
            target_q    <= '0;
            rr_q        <= 1'b0;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            ramp_busy_q <= 1'b0;
        end else if (fault) begin
            state_q     <= StFault;
            d_inv_q     <= '0;
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            ramp_busy_q <= 1'b0;
        end else if (state_q == StFault) begin
            gnt_a_q     <= 1'b0;
            gnt_b_q     <= 1'b0;
            ramp_busy_q <= 1'b0;
            if (!ce) begin
                state_q  <= StIdle;
                target_q <= '0;
            end
        end else begin
            gnt_a_q <= ce && win_a;
            gnt_b_q <= ce && win_b;
            if (!ce) begin
                target_q <= '0;
            end else if (win_a) begin
                target_q <= set_a_cl;
                rr_q     <= 1'b1;
            end else if (win_b) begin
                target_q <= set_b_cl;
                rr_q     <= 1'b0;
            end
            d_inv_q     <= d_next;
            state_q     <= st_norm;
            ramp_busy_q <= (st_norm == StRamp);
        end
    end

    assign d_inv     = d_inv_q;
    assign state     = state_q;
    assign gnt_a     = gnt_a_q;
    assign gnt_b     = gnt_b_q;
    assign ramp_busy = ramp_busy_q;

endmodule

// File: doc/inv_duty_ctrl.md
INV_DUTY_CTRL -- requirements
Module: inv_duty_ctrl

Interface
REQ-001 The block SHALL take parameter DW, default 10, as the duty word width.
REQ-002 The block SHALL take parameter DMAX, default 1000, as the maximum duty code; accepted setpoints above it are clamped to it.
REQ-003 The block SHALL take parameter STEP, default 4, as the maximum duty change per update tick.
REQ-004 The block SHALL have port clk, input, 1 bit, the single system clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit; reset is synchronous and active-low.
REQ-006 The block SHALL have port ce, input, 1 bit, the inverter run enable.
REQ-007 The block SHALL have port upd_tick, input, 1 bit, a one-clk pulse at each PWM period boundary.
REQ-008 The block SHALL have ports req_a and req_b, input, 1 bit each, the setpoint requests from requesters A and B.
REQ-009 The block SHALL have ports set_a and set_b, input, DW bits each, the requested duty setpoints.
REQ-010 The block SHALL have ports gnt_a and gnt_b, output, 1 bit each, one-clk acceptance pulses.
REQ-011 The block SHALL have port fault, input, 1 bit, the bridge fault (level).
REQ-012 The block SHALL have port d_inv, output, DW bits, the duty word sent to the PWM/deadtime stage.
REQ-013 The block SHALL have port state, output, 2 bits: IDLE=00, RAMP=01, HOLD=10, FAULT=11.
REQ-014 The block SHALL have port ramp_busy, output, 1 bit, high while state==RAMP.

Function
REQ-015 Arbitration: a request SHALL be granted only if ce=1, fault=0 and state!=FAULT; if both requesters are pending, grant round-robin (pointer flips to the other requester after each grant).
REQ-016 Grant: the gnt_x pulse SHALL be registered one clk after req_x is sampled, and target SHALL load min(set_x, DMAX) in the same clk.
REQ-017 Requests SHALL be level-sampled; a requester holding req high is re-granted every clk it wins arbitration.
REQ-018 ce=0 outside FAULT SHALL force target to 0 each clk; no grants are issued.
REQ-019 d_inv SHALL change only in the clk after upd_tick=1, in state RAMP, by +/-min(STEP, |target-d_inv|), toward target.
REQ-020 Simultaneity: an upd_tick and a grant in the same clk SHALL use the old target; the new target takes effect at the next tick.
REQ-021 Transitions IDLE/HOLD->RAMP SHALL occur the clk after target!=d_inv.
REQ-022 Transitions RAMP->HOLD (target!=0) or RAMP->IDLE (target==0) SHALL occur in the same clk that d_inv reaches target.
REQ-023 d_inv arithmetic SHALL never wrap; results are bounded to [0, DMAX].
REQ-024 fault=1 in any state SHALL move to FAULT and set d_inv=0 on the next clk, overriding ticks and grants (no gnt issued that clk).
REQ-025 FAULT SHALL be exited to IDLE only on a clk with fault=0 and ce=0; target is cleared on exit.

Reset
REQ-026 rst_n=0 sampled at a clk edge SHALL set d_inv=0, target=0, state=IDLE, gnt_a=gnt_b=0, ramp_busy=0, with the round-robin pointer favouring A.
REQ-027 Reset mid-ramp or in FAULT SHALL have the same result, without ramping down.

Configuration
REQ-028 With macro INV_SOFTSTART_EN defined, d_inv SHALL step by at most STEP per tick as in REQ-019.
REQ-029 Without INV_SOFTSTART_EN, d_inv SHALL load target on the first tick in RAMP, so RAMP lasts exactly one tick; all other behaviour is unchanged.

Verification
REQ-030 Soft start: with INV_SOFTSTART_EN and ce=1, req_a with set_a=20 -> gnt_a pulse, then d_inv=4,8,12,16,20 on 5 successive ticks, then state=HOLD.
REQ-031 Contention: req_a and req_b both high from reset for 2 clks -> gnt_a in the first clk, gnt_b in the next, final target=set_b.
REQ-032 Clamp and no wrap: set_a=1023 -> target=1000; ramp ends at d_inv=1000; a new set_a=2 then ramps down by 4 per tick to 2, never below.
REQ-033 Fault: fault=1 at d_inv=500 -> d_inv=0 and state=11 on the next clk; a req_a during fault gets no grant; fault=0 with ce=1 stays in FAULT; ce=0 then -> IDLE.
REQ-034 ce drop and reset: at d_inv=12, HOLD, ce=0 -> ramps 8,4,0 then IDLE; rst_n=0 mid-ramp -> all outputs reset on the next clk.
REQ-035 Macro off: without INV_SOFTSTART_EN, set_a=300 -> d_inv=300 on the first tick; RAMP lasts one tick.
